// File: rtl/mask_window_threshold_if.sv
// rtl/mask_window_threshold_if.sv - pixel input stream bundle for mask_window_threshold
interface mask_window_threshold_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3
);
    logic                      valid_in;
    logic [CHANNELS*WIDTH-1:0] pixel_in;
    logic                      line_start_in;
    logic                      frame_start_in;

    modport master (
        output valid_in,
        output pixel_in,
        output line_start_in,
        output frame_start_in
    );

    modport slave (
        input valid_in,
        input pixel_in,
        input line_start_in,
        input frame_start_in
    );
endinterface

// File: rtl/mask_window_threshold.sv
// rtl/mask_window_threshold.sv - per-channel window threshold, run filter and frame mask count
module mask_window_threshold #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int RUN_LEN  = 4,
    parameter int COUNT_W  = 20
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    mask_window_threshold_if.slave    pix_if,
    input  logic [CHANNELS*WIDTH-1:0] lower_bound_in,
    input  logic [CHANNELS*WIDTH-1:0] upper_bound_in,
    input  logic [CHANNELS-1:0]       invert_in,
    input  logic                      combine_in,
    input  logic                      bounds_load_in,
    output logic                      valid_out,
    output logic                      mask_out,
    output logic                      raw_mask_out,
    output logic [COUNT_W-1:0]        count_out,
    output logic                      frame_done_out
);
    localparam int CW = CHANNELS * WIDTH;
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

    // Configuration: active set drives comparison, pending set waits for a frame start
    logic [CW-1:0]       act_lo_q, act_lo_d, act_up_q, act_up_d;
    logic [CHANNELS-1:0] act_inv_q, act_inv_d;
    logic                act_comb_q, act_comb_d;
    logic [CW-1:0]       pend_lo_q, pend_lo_d, pend_up_q, pend_up_d;
    logic [CHANNELS-1:0] pend_inv_q, pend_inv_d;
    logic                pend_comb_q, pend_comb_d;
    logic                pend_flag_q, pend_flag_d;

    // Stage 1
    logic [CHANNELS-1:0] p1_q, p1_d;
    logic                comb1_q, comb1_d;
    logic                v1_q, v1_d, ls1_q, ls1_d, fs1_q, fs1_d;

    // Stage 2
    logic [RW-1:0]       run_q, run_d;
    logic [COUNT_W-1:0]  acc_q, acc_d, count_q, count_d;
    logic                valid_q, valid_d, mask_q, mask_d, raw_q, raw_d, done_q, done_d;

    logic                load_now;
    logic [CW-1:0]       eff_lo, eff_up;
    logic [CHANNELS-1:0] eff_inv;
    logic                eff_comb;
    logic                raw_now, mask_now;
    logic [RW-1:0]       run_next;

    always_comb begin
        // A frame-start pixel compares against the set it promotes
        load_now = pix_if.valid_in && pix_if.frame_start_in && pend_flag_q;
        eff_lo   = load_now ? pend_lo_q   : act_lo_q;
        eff_up   = load_now ? pend_up_q   : act_up_q;
        eff_inv  = load_now ? pend_inv_q  : act_inv_q;
        eff_comb = load_now ? pend_comb_q : act_comb_q;

        act_lo_d   = eff_lo;
        act_up_d   = eff_up;
        act_inv_d  = eff_inv;
        act_comb_d = eff_comb;

        pend_lo_d   = pend_lo_q;
        pend_up_d   = pend_up_q;
        pend_inv_d  = pend_inv_q;
        pend_comb_d = pend_comb_q;
        pend_flag_d = pend_flag_q && !load_now;
        if (bounds_load_in) begin
            pend_lo_d   = lower_bound_in;
            pend_up_d   = upper_bound_in;
            pend_inv_d  = invert_in;
            pend_comb_d = combine_in;
            pend_flag_d = 1'b1;
        end

        p1_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            p1_d[c] = ((pix_if.pixel_in[c*WIDTH +: WIDTH] >  eff_lo[c*WIDTH +: WIDTH]) &&
                       (pix_if.pixel_in[c*WIDTH +: WIDTH] <= eff_up[c*WIDTH +: WIDTH])) ^ eff_inv[c];
        end
        comb1_d = eff_comb;
        v1_d    = pix_if.valid_in;
        ls1_d   = pix_if.line_start_in;
        fs1_d   = pix_if.frame_start_in;

        raw_now = comb1_q ? (|p1_q) : (&p1_q);
        if (ls1_q || fs1_q) begin
            run_next = raw_now ? RW'(1) : '0;
        end else if (!raw_now) begin
            run_next = '0;
        end else begin
            run_next = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
        end
        mask_now = raw_now && (run_next == RUN_MAX);

        run_d   = run_q;
        acc_d   = acc_q;
        count_d = count_q;
        valid_d = v1_q;
        raw_d   = 1'b0;
        mask_d  = 1'b0;
        done_d  = 1'b0;
        if (v1_q) begin
            run_d  = run_next;
            raw_d  = raw_now;
            mask_d = mask_now;
            if (fs1_q) begin
                count_d = acc_q;
                done_d  = 1'b1;
                acc_d   = COUNT_W'(mask_now);
            end else if (mask_now && (acc_q != {COUNT_W{1'b1}})) begin
                acc_d = acc_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            act_lo_q    <= '0;
            act_up_q    <= '1;
            act_inv_q   <= '0;
            act_comb_q  <= 1'b0;
            pend_lo_q   <= '0;
            pend_up_q   <= '1;
            pend_inv_q  <= '0;
            pend_comb_q <= 1'b0;
            pend_flag_q <= 1'b0;
            p1_q        <= '0;
            comb1_q     <= 1'b0;
            v1_q        <= 1'b0;
            ls1_q       <= 1'b0;
            fs1_q       <= 1'b0;
            run_q       <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            mask_q      <= 1'b0;
            raw_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            act_lo_q    <= act_lo_d;
            act_up_q    <= act_up_d;
            act_inv_q   <= act_inv_d;
            act_comb_q  <= act_comb_d;
            pend_lo_q   <= pend_lo_d;
            pend_up_q   <= pend_up_d;
            pend_inv_q  <= pend_inv_d;
            pend_comb_q <= pend_comb_d;
            pend_flag_q <= pend_flag_d;
            p1_q        <= p1_d;
            comb1_q     <= comb1_d;
            v1_q        <= v1_d;
            ls1_q       <= ls1_d;
            fs1_q       <= fs1_d;
            run_q       <= run_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            mask_q      <= mask_d;
            raw_q       <= raw_d;
            done_q      <= done_d;
        end
    end

    assign valid_out      = valid_q;
    assign mask_out       = mask_q;
    assign raw_mask_out   = raw_q;
    assign count_out      = count_q;
    assign frame_done_out = done_q;
endmodule

// File: tb/tb_mask_window_threshold.sv
// tb/tb_mask_window_threshold.sv - directed self-checking bench for mask_window_threshold
module tb_mask_window_threshold;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // DUT A: 3 channels, RUN_LEN 4, COUNT_W 20
    mask_window_threshold_if #(.WIDTH(8), .CHANNELS(3)) if_a ();
    logic [23:0] lo_a = '0, up_a = '1;
    logic [2:0]  inv_a = '0;
    logic        comb_a = 1'b0, ld_a = 1'b0;
    logic        vo_a, mask_a, raw_a, fd_a;
    logic [19:0] cnt_a;

    mask_window_threshold #(.WIDTH(8), .CHANNELS(3), .RUN_LEN(4), .COUNT_W(20)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .pix_if(if_a),
        .lower_bound_in(lo_a), .upper_bound_in(up_a), .invert_in(inv_a),
        .combine_in(comb_a), .bounds_load_in(ld_a),
        .valid_out(vo_a), .mask_out(mask_a), .raw_mask_out(raw_a),
        .count_out(cnt_a), .frame_done_out(fd_a)
    );

    // DUT B: 1 channel, RUN_LEN 1, COUNT_W 2
    mask_window_threshold_if #(.WIDTH(8), .CHANNELS(1)) if_b ();
    logic [7:0] lo_b = '0, up_b = '1;
    logic [0:0] inv_b = '0;
    logic       comb_b = 1'b0, ld_b = 1'b0;
    logic       vo_b, mask_b, raw_b, fd_b;
    logic [1:0] cnt_b;

    mask_window_threshold #(.WIDTH(8), .CHANNELS(1), .RUN_LEN(1), .COUNT_W(2)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .pix_if(if_b),
        .lower_bound_in(lo_b), .upper_bound_in(up_b), .invert_in(inv_b),
        .combine_in(comb_b), .bounds_load_in(ld_b),
        .valid_out(vo_b), .mask_out(mask_b), .raw_mask_out(raw_b),
        .count_out(cnt_b), .frame_done_out(fd_b)
    );

    // Output record: {raw, mask, frame_done, count}
    logic [22:0] qa[$];
    always @(negedge clk) if (vo_a) qa.push_back({raw_a, mask_a, fd_a, cnt_a});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_a(output logic [22:0] e);
        if (qa.size() > 0) e = qa.pop_front();
        else e = 'x;
    endtask

    task automatic bubble();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        repeat (3) bubble();
    endtask

    task automatic pa(input logic [23:0] px, input logic ls, input logic fs, input logic ld);
        if_a.valid_in = 1'b1; if_a.pixel_in = px;
        if_a.line_start_in = ls; if_a.frame_start_in = fs; ld_a = ld;
        @(posedge clk); #1;
        if_a.valid_in = 1'b0; if_a.line_start_in = 1'b0; if_a.frame_start_in = 1'b0; ld_a = 1'b0;
    endtask

    task automatic set_cfg(input logic [23:0] lo, input logic [23:0] up, input logic [2:0] inv, input logic cb);
        lo_a = lo; up_a = up; inv_a = inv; comb_a = cb;
    endtask

    task automatic load_cfg(input logic [23:0] lo, input logic [23:0] up, input logic [2:0] inv, input logic cb);
        set_cfg(lo, up, inv, cb);
        ld_a = 1'b1;
        @(posedge clk); #1;
        ld_a = 1'b0;
    endtask

    task automatic pb_chk(input string tag, input logic [7:0] px, input logic fs, input logic exp_raw);
        if_b.valid_in = 1'b1; if_b.pixel_in = px; if_b.frame_start_in = fs; if_b.line_start_in = 1'b0;
        @(posedge clk); #1;
        if_b.valid_in = 1'b0; if_b.frame_start_in = 1'b0;
        check({tag, "_lat1"}, vo_b, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, vo_b, 1);
        check({tag, "_raw"}, raw_b, exp_raw);
        check({tag, "_mask"}, mask_b, exp_raw);
    endtask

    localparam logic [23:0] PASS = 24'h808080;
    localparam logic [23:0] FAILPX = 24'h000000;
    localparam logic [23:0] P50 = 24'h323232;

    initial begin
        logic [22:0] e;
        logic [9:0]  pat, msk;
        logic [6:0]  msk2;
        logic [7:0]  fr2;

        if_a.valid_in = 0; if_a.pixel_in = '0; if_a.line_start_in = 0; if_a.frame_start_in = 0;
        if_b.valid_in = 0; if_b.pixel_in = '0; if_b.line_start_in = 0; if_b.frame_start_in = 0;

        #2;
        check("rst_valid_a", vo_a, 0);
        check("rst_count_a", cnt_a, 0);
        check("rst_fd_a", fd_a, 0);
        check("rst_valid_b", vo_b, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single channel window (10,20], RUN_LEN 1, 2-cycle latency
        lo_b = 8'd10; up_b = 8'd20; ld_b = 1'b1;
        @(posedge clk); #1; ld_b = 1'b0;
        pb_chk("b10", 8'd10, 1, 0);
        check("b_first_fd", fd_b, 1);
        check("b_first_count", cnt_b, 0);
        pb_chk("b11", 8'd11, 0, 1);
        pb_chk("b20", 8'd20, 0, 1);
        pb_chk("b21", 8'd21, 1, 0);
        check("b_count2", cnt_b, 2);
        for (int i = 0; i < 5; i++) pb_chk("bhit", 8'd15, 0, 1);
        pb_chk("bsat_fs", 8'd15, 1, 1);
        check("b_sat_count", cnt_b, 3);
        check("b_sat_fd", fd_b, 1);

        // Combine: ch0 passes, ch1/ch2 fail
        qa.delete();
        load_cfg(24'h64640A, 24'hC8C814, 3'b000, 0);
        pa(24'h32320F, 0, 1, 0); drain(); pop_a(e);
        check("and_raw", e[22], 0);
        check("first_fs_fd", e[20], 1);
        check("first_fs_count", e[19:0], 0);
        load_cfg(24'h64640A, 24'hC8C814, 3'b000, 1);
        pa(24'h32320F, 0, 1, 0); drain(); pop_a(e);
        check("or_raw", e[22], 1);
        load_cfg(24'h64640A, 24'hC8C814, 3'b010, 0);
        pa(24'h32320F, 0, 1, 0); drain(); pop_a(e);
        check("inv1_and_raw", e[22], 0);
        load_cfg(24'h32640A, 24'h32C814, 3'b110, 0);
        pa(24'h32320F, 0, 1, 0); drain(); pop_a(e);
        check("empty_inv_raw", e[22], 1);

        // Run filter with bubbles
        load_cfg(24'h000000, 24'hFFFFFF, 3'b000, 0);
        pat = 10'b1110111111;
        msk = 10'b0000111000;
        for (int i = 0; i < 10; i++) begin
            pa(pat[i] ? PASS : FAILPX, 0, i == 0, 0);
            if (i % 2 == 1) bubble();
        end
        drain();
        for (int i = 0; i < 10; i++) begin
            pop_a(e);
            check($sformatf("run_raw%0d", i), e[22], pat[i]);
            check($sformatf("run_mask%0d", i), e[21], msk[i]);
            if (i > 0) check($sformatf("run_fd%0d", i), e[20], 0);
        end
        msk2 = 7'b1000000;
        for (int i = 0; i < 7; i++) pa(PASS, (i == 0) || (i == 3), 0, 0);
        drain();
        for (int i = 0; i < 7; i++) begin
            pop_a(e);
            check($sformatf("ls_mask%0d", i), e[21], msk2[i]);
        end

        // Frame counts: 4 (previous frame), then 5, then 3
        fr2 = 8'b00111111;
        for (int i = 0; i < 8; i++) pa(PASS, 0, i == 0, 0);
        for (int i = 0; i < 8; i++) pa(fr2[i] ? PASS : FAILPX, 0, i == 0, 0);
        pa(P50, 0, 1, 0);
        drain();
        pop_a(e);
        check("f1_fd", e[20], 1);
        check("f1_count", e[19:0], 4);
        for (int i = 0; i < 7; i++) pop_a(e);
        pop_a(e);
        check("f2_fd", e[20], 1);
        check("f2_count", e[19:0], 5);
        for (int i = 0; i < 7; i++) pop_a(e);
        pop_a(e);
        check("f3_fd", e[20], 1);
        check("f3_count", e[19:0], 3);
        check("f3_raw", e[22], 1);

        // Bounds load mid-frame and coincident with frame start
        load_cfg(24'h000064, 24'hFFFFFF, 3'b000, 0);
        pa(P50, 0, 0, 0);
        set_cfg(24'h000000, 24'hFFFFFF, 3'b000, 0);
        pa(P50, 0, 1, 1);
        pa(P50, 0, 0, 0);
        pa(P50, 0, 1, 0);
        drain();
        pop_a(e); check("ld_mid_raw", e[22], 1);
        pop_a(e); check("ld_fs_raw", e[22], 0);
        pop_a(e); check("ld_coinc_raw", e[22], 0);
        pop_a(e); check("ld_next_raw", e[22], 1);

        // Asynchronous reset with pixels in flight
        load_cfg(24'h000064, 24'hFFFFFF, 3'b000, 0);
        pa(P50, 0, 1, 0);
        load_cfg(24'h000064, 24'hFFFFFF, 3'b000, 0);
        drain();
        pop_a(e); check("pre_rst_raw", e[22], 0);
        qa.delete();
        pa(P50, 0, 0, 0);
        pa(P50, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", vo_a, 0);
        check("arst_raw", raw_a, 0);
        check("arst_mask", mask_a, 0);
        check("arst_count", cnt_a, 0);
        check("arst_fd", fd_a, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) bubble();
        check("no_inflight", qa.size(), 0);
        pa(P50, 0, 1, 0);
        drain();
        pop_a(e);
        check("post_rst_raw", e[22], 1);
        check("post_rst_fd", e[20], 1);
        check("post_rst_count", e[19:0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
